// File: rtl/stack_ctrl_if.sv
// rtl/stack_ctrl_if.sv - request, stack-pointer and memory signals of the stack controller
interface stack_ctrl_if #(
  parameter int AW = 16
);
  logic          pushReq;
  logic          popReq;
  logic [15:0]   pushData;
  logic [15:0]   popData;
  logic          ack;
  logic          busy;
  logic          full;
  logic          empty;
  logic          fault;
  logic          spInc;
  logic          spDec;
  logic [AW-1:0] spData;
  logic [AW-1:0] memAddr;
  logic          memWrite;
  logic          memRead;
  logic [15:0]   memWriteData;
  logic [15:0]   memReadData;

  // Controller side
  modport slave (
    input  pushReq, popReq, pushData, spData, memReadData,
    output popData, ack, busy, full, empty, fault, spInc, spDec,
           memAddr, memWrite, memRead, memWriteData
  );

  // Requester, SP register and memory side
  modport master (
    output pushReq, popReq, pushData, spData, memReadData,
    input  popData, ack, busy, full, empty, fault, spInc, spDec,
           memAddr, memWrite, memRead, memWriteData
  );
endinterface

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - push/pop sequencer for a memory-backed stack with external SP register
module stack_ctrl #(
  parameter int DEPTH = 256,
  parameter int AW    = 16
) (
  input  logic         clock,
  input  logic         reset,
  stack_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    PUSH,
    POP_RD,
    POP_CAP,
    DONE,
    REJECT
  } state_t;

  localparam logic [AW-1:0] SP_MAX = AW'(DEPTH);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] push_word;
  logic [15:0] pop_word;
  logic        can_push;
  logic        can_pop;

  // Push guard uses "<" so an out-of-range SP can never be incremented further.
  assign can_push = (bus.spData < SP_MAX);
  assign can_pop  = (bus.spData != '0);

  assign bus.full    = (bus.spData == SP_MAX);
  assign bus.empty   = (bus.spData == '0);
  assign bus.busy    = (state != IDLE);
  assign bus.popData = pop_word;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      push_word <= 16'd0;
      pop_word  <= 16'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.pushReq && can_push) begin
        push_word <= bus.pushData;
      end
      if (state == POP_CAP) begin
        pop_word <= bus.memReadData;
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    bus.ack          = 1'b0;
    bus.fault        = 1'b0;
    bus.spInc        = 1'b0;
    bus.spDec        = 1'b0;
    bus.memAddr      = '0;
    bus.memWrite     = 1'b0;
    bus.memRead      = 1'b0;
    bus.memWriteData = 16'd0;

    case (state)
      IDLE: begin
        // Push wins over a simultaneous pop; the pop is simply dropped.
        if (bus.pushReq) begin
          state_nxt = can_push ? PUSH : REJECT;
        end else if (bus.popReq) begin
          state_nxt = can_pop ? POP_RD : REJECT;
        end
      end
      PUSH: begin
        bus.memWrite     = 1'b1;
        bus.memAddr      = bus.spData;
        bus.memWriteData = push_word;
        bus.spInc        = 1'b1;
        state_nxt        = DONE;
      end
      POP_RD: begin
        bus.memRead = 1'b1;
        bus.memAddr = bus.spData - AW'(1);
        bus.spDec   = 1'b1;
        state_nxt   = POP_CAP;
      end
      POP_CAP: begin
        bus.ack   = 1'b1;
        state_nxt = IDLE;
      end
      DONE: begin
        bus.ack   = 1'b1;
        state_nxt = IDLE;
      end
      REJECT: begin
        bus.ack   = 1'b1;
        bus.fault = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// tb/tb_stack_ctrl.sv - directed self-checking bench for stack_ctrl
module tb_stack_ctrl;

  localparam int DEPTH = 256;
  localparam int AW    = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;

  stack_ctrl_if #(.AW(AW)) bus ();

  stack_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Environment: SP register and synchronous-read stack memory
  logic [AW-1:0] sp;
  logic          sp_load = 1'b0;
  logic [AW-1:0] sp_val  = '0;
  logic [15:0]   mem [0:255];
  logic [15:0]   rdata = 16'd0;

  always @(posedge clock or posedge reset) begin
    if (reset)        sp <= '0;
    else if (sp_load) sp <= sp_val;
    else if (bus.spInc) sp <= sp + 16'd1;
    else if (bus.spDec) sp <= sp - 16'd1;
  end

  always @(posedge clock) begin
    if (bus.memWrite) mem[bus.memAddr[7:0]] <= bus.memWriteData;
    if (bus.memRead)  rdata <= mem[bus.memAddr[7:0]];
  end

  assign bus.spData      = sp;
  assign bus.memReadData = rdata;

  int total  = 0;
  int passes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic load_sp(input logic [AW-1:0] v);
    sp_load = 1'b1;
    sp_val  = v;
    step();
    sp_load = 1'b0;
  endtask

  task automatic do_push(input string tag, input logic [15:0] d, input logic [15:0] addr);
    bus.pushReq  = 1'b1;
    bus.pushData = d;
    step();
    chk({tag, " memWrite"}, 32'(bus.memWrite), 32'd1);
    chk({tag, " memAddr"}, 32'(bus.memAddr), 32'(addr));
    chk({tag, " memWriteData"}, 32'(bus.memWriteData), 32'(d));
    chk({tag, " spInc"}, 32'(bus.spInc), 32'd1);
    chk({tag, " ack early"}, 32'(bus.ack), 32'd0);
    step();
    chk({tag, " spInc once"}, 32'(bus.spInc), 32'd0);
    chk({tag, " ack"}, 32'(bus.ack), 32'd1);
    chk({tag, " fault"}, 32'(bus.fault), 32'd0);
    bus.pushReq = 1'b0;
    step();
    chk({tag, " ack one cycle"}, 32'(bus.ack), 32'd0);
  endtask

  task automatic do_pop(input string tag, input logic [15:0] addr, input logic [15:0] d);
    bus.popReq = 1'b1;
    step();
    chk({tag, " memRead"}, 32'(bus.memRead), 32'd1);
    chk({tag, " memWrite"}, 32'(bus.memWrite), 32'd0);
    chk({tag, " memAddr"}, 32'(bus.memAddr), 32'(addr));
    chk({tag, " spDec"}, 32'(bus.spDec), 32'd1);
    step();
    chk({tag, " ack"}, 32'(bus.ack), 32'd1);
    chk({tag, " spDec once"}, 32'(bus.spDec), 32'd0);
    bus.popReq = 1'b0;
    step();
    chk({tag, " popData"}, 32'(bus.popData), 32'(d));
  endtask

  initial begin
    bus.pushReq  = 1'b0;
    bus.popReq   = 1'b0;
    bus.pushData = 16'd0;
    repeat (2) step();

    chk("rst ack", 32'(bus.ack), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst memAddr", 32'(bus.memAddr), 32'd0);
    chk("rst memWriteData", 32'(bus.memWriteData), 32'd0);
    chk("rst popData", 32'(bus.popData), 32'd0);
    chk("rst empty", 32'(bus.empty), 32'd1);
    reset = 1'b0;
    step();

    do_push("push_a5a5", 16'hA5A5, 16'd0);
    chk("push_a5a5 sp", 32'(sp), 32'd1);

    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    do_push("push_1111", 16'h1111, 16'd0);
    do_push("push_2222", 16'h2222, 16'd1);
    do_pop("pop_2222", 16'd1, 16'h2222);
    do_pop("pop_1111", 16'd0, 16'h1111);
    chk("lifo empty", 32'(bus.empty), 32'd1);

    // Underflow
    bus.popReq = 1'b1;
    step();
    chk("underflow ack", 32'(bus.ack), 32'd1);
    chk("underflow fault", 32'(bus.fault), 32'd1);
    chk("underflow memRead", 32'(bus.memRead), 32'd0);
    chk("underflow spDec", 32'(bus.spDec), 32'd0);
    bus.popReq = 1'b0;
    step();
    chk("underflow ack one cycle", 32'(bus.ack), 32'd0);
    chk("underflow fault one cycle", 32'(bus.fault), 32'd0);

    // Overflow
    load_sp(16'(DEPTH));
    chk("full flag", 32'(bus.full), 32'd1);
    bus.pushReq  = 1'b1;
    bus.pushData = 16'h5A5A;
    step();
    chk("overflow ack", 32'(bus.ack), 32'd1);
    chk("overflow fault", 32'(bus.fault), 32'd1);
    chk("overflow memWrite", 32'(bus.memWrite), 32'd0);
    chk("overflow spInc", 32'(bus.spInc), 32'd0);
    bus.pushReq = 1'b0;
    step();
    chk("overflow sp held", 32'(sp), 32'(DEPTH));

    // Simultaneous push and pop at SP=3: push only
    load_sp(16'd3);
    bus.pushReq  = 1'b1;
    bus.popReq   = 1'b1;
    bus.pushData = 16'hBEEF;
    step();
    chk("both memWrite", 32'(bus.memWrite), 32'd1);
    chk("both memAddr", 32'(bus.memAddr), 32'd3);
    chk("both memRead", 32'(bus.memRead), 32'd0);
    chk("both spDec", 32'(bus.spDec), 32'd0);
    step();
    chk("both ack", 32'(bus.ack), 32'd1);
    chk("both fault", 32'(bus.fault), 32'd0);
    bus.pushReq = 1'b0;
    bus.popReq  = 1'b0;
    step();
    chk("both memRead after", 32'(bus.memRead), 32'd0);
    chk("both sp", 32'(sp), 32'd4);

    // Reset during POP_RD
    bus.popReq = 1'b1;
    step();
    chk("abort memRead before", 32'(bus.memRead), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("abort memRead", 32'(bus.memRead), 32'd0);
    chk("abort spDec", 32'(bus.spDec), 32'd0);
    chk("abort memAddr", 32'(bus.memAddr), 32'd0);
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort popData", 32'(bus.popData), 32'd0);
    bus.popReq = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort no ack", 32'(bus.ack), 32'd0);
      chk("abort idle", 32'(bus.busy), 32'd0);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
